// File: rtl/mem_sched_pkg.sv
// Shared helpers for the memory round-robin scheduler: one-hot decoding
// and the depth of the read-tag pipeline relative to memory latency.
package mem_sched_pkg;

  // Widest requester vector the one-hot decoder accepts.
  localparam int MAX_N = 32;

  // Tag pipeline runs one stage past the memory latency: one stage for the
  // command issue register, MEM_LAT stages for the macro itself.
  localparam int TAG_EXTRA = 1;

  function automatic int tag_depth(input int mem_lat);
    return mem_lat + TAG_EXTRA;
  endfunction

  // Index of the set bit in a one-hot vector (0 when the vector is zero).
  function automatic int unsigned onehot_to_index(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: either holds the sticky requester or
// grants the first valid requester found scanning upward from start.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic                 sticky_en,
  input  logic [$clog2(N)-1:0] sticky_idx,
  output logic [N-1:0]         grant
);

  localparam int IDX_W = $clog2(N);

  // Sticky tenure wins outright; otherwise a wrapping first-valid scan.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (sticky_en) begin
      grant[sticky_idx] = req[sticky_idx];
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = IDX_W'((int'(start) + k) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Shares one single-port synchronous memory among N requesters using
// round-robin arbitration with a burst quantum. Commands are registered
// onto the memory port; read data is routed back by a one-hot tag pipeline.
module mem_rr_scheduler
  import mem_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1,
  parameter int QUANTUM    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N-1:0]                     req_valid,
  output logic [N-1:0]                     req_ready,
  input  logic [N-1:0]                     req_we,
  input  logic [N-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [N-1:0][DATA_WIDTH-1:0]     req_wdata,
  output logic [N-1:0]                     rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IDX_W     = $clog2(N);
  localparam int CNT_W     = $clog2(QUANTUM + 1);
  localparam int TAG_DEPTH = tag_depth(MEM_LAT);

  logic [IDX_W-1:0]              cur;
  logic [CNT_W-1:0]              cnt;
  logic [IDX_W-1:0]              start;
  logic                          sticky;
  logic [N-1:0]                  pick;
  logic [N-1:0]                  grant;
  logic                          any_grant;
  logic [IDX_W-1:0]              gidx;
  logic [TAG_DEPTH-1:0][N-1:0]   tag_p;

  // Tenure continues while the quantum has room and the owner still asks.
  assign sticky = (cnt != '0) && (cnt < CNT_W'(QUANTUM)) && req_valid[cur];
  assign start  = (cur == IDX_W'(N - 1)) ? '0 : cur + IDX_W'(1);

  rr_pick #(.N(N)) u_pick (
    .req        (req_valid),
    .start      (start),
    .sticky_en  (sticky),
    .sticky_idx (cur),
    .grant      (pick)
  );

  assign grant     = rst ? '0 : pick;
  assign req_ready = grant;
  assign any_grant = |grant;
  assign gidx      = IDX_W'(onehot_to_index(MAX_N'(grant)));

  // Arbitration state: owner index and consecutive-grant count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDX_W'(N - 1);
      cnt <= '0;
    end else if (!any_grant) begin
      cnt <= '0;
    end else if (gidx == cur) begin
      cnt <= (cnt >= CNT_W'(QUANTUM)) ? CNT_W'(1) : cnt + CNT_W'(1);
    end else begin
      cur <= gidx;
      cnt <= CNT_W'(1);
    end
  end

  // Stage p0 -> memory port: register the accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (any_grant) begin
      mem_en    <= 1'b1;
      mem_we    <= req_we[gidx];
      mem_addr  <= req_addr[gidx];
      mem_wdata <= req_wdata[gidx];
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Read tag pipeline: one-hot owner of each read, aligned with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_p <= '0;
    end else begin
      tag_p[0] <= grant & ~req_we;
      for (int d = 1; d < TAG_DEPTH; d++) begin
        tag_p[d] <= tag_p[d-1];
      end
    end
  end

  // Response stage: steer read data to the tagged requester, zero otherwise.
  always_comb begin
    rsp_valid = tag_p[TAG_DEPTH-1];
    rsp_data  = (|tag_p[TAG_DEPTH-1]) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed bench for mem_rr_scheduler. Instance A: MEM_LAT=1, QUANTUM=4.
// Instance B: MEM_LAT=3, QUANTUM=1. Each instance has a behavioural memory.
module tb_mem_rr_scheduler;

  logic clk;
  logic rst;

  logic [3:0]       valid_a, ready_a, we_a, rspv_a;
  logic [3:0][7:0]  addr_a;
  logic [3:0][31:0] wdata_a;
  logic [31:0]      rspd_a, mwdata_a, mrdata_a;
  logic             men_a, mwe_a;
  logic [7:0]       maddr_a;

  logic [3:0]       valid_b, ready_b, we_b, rspv_b;
  logic [3:0][7:0]  addr_b;
  logic [3:0][31:0] wdata_b;
  logic [31:0]      rspd_b, mwdata_b, mrdata_b;
  logic             men_b, mwe_b;
  logic [7:0]       maddr_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] b_r0, b_r1, b_r2;

  int n_chk;
  int n_fail;

  mem_rr_scheduler #(.N(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_LAT(1), .QUANTUM(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_we(we_a),
    .req_addr(addr_a), .req_wdata(wdata_a), .rsp_valid(rspv_a), .rsp_data(rspd_a),
    .mem_en(men_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
    .mem_rdata(mrdata_a)
  );

  mem_rr_scheduler #(.N(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_LAT(3), .QUANTUM(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_we(we_b),
    .req_addr(addr_b), .req_wdata(wdata_b), .rsp_valid(rspv_b), .rsp_data(rspd_b),
    .mem_en(men_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_rdata(mrdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: one-cycle read latency, writable.
  always @(posedge clk) begin
    if (men_a) begin
      if (mwe_a) mem_a[maddr_a] <= mwdata_a;
      else       mrdata_a       <= mem_a[maddr_a];
    end
  end

  // Memory B: three-cycle read latency, read-only preloaded contents.
  always @(posedge clk) begin
    if (men_b && !mwe_b) b_r0 <= mem_b[maddr_b];
    b_r1 <= b_r0;
    b_r2 <= b_r1;
  end
  assign mrdata_b = b_r2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    valid_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_seq3 [7] = '{1, 3, 1, 3, 1, 1, 1};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem_b[i] = 32'h100 + i;

    // Reset state with every requester asking
    rst = 1'b1;
    clear_inputs();
    valid_a = 4'hF;
    tick();
    tick();
    chk("rst_ready", ready_a, 0);
    chk("rst_mem_en", men_a, 0);
    chk("rst_mem_we", mwe_a, 0);
    chk("rst_mem_addr", maddr_a, 0);
    chk("rst_mem_wdata", mwdata_a, 0);
    chk("rst_rsp_valid", rspv_a, 0);
    chk("rst_rsp_data", rspd_a, 0);

    // Requester 2: two writes to 0x10 then read back
    do_reset();
    valid_a = 4'b0100; we_a = 4'b0100;
    addr_a[2] = 8'h10; wdata_a[2] = 32'h1111_1111;
    #1;
    chk("t1_ready0", ready_a, 4'b0100);
    tick();
    wdata_a[2] = 32'hA5A5_0001;
    #1;
    chk("t1_en1", men_a, 1);
    chk("t1_we1", mwe_a, 1);
    chk("t1_addr1", maddr_a, 8'h10);
    chk("t1_wdata1", mwdata_a, 32'h1111_1111);
    chk("t1_ready1", ready_a, 4'b0100);
    tick();
    we_a = 4'b0000;
    #1;
    chk("t1_en2", men_a, 1);
    chk("t1_wdata2", mwdata_a, 32'hA5A5_0001);
    chk("t1_ready2", ready_a, 4'b0100);
    tick();
    valid_a = 4'b0000;
    #1;
    chk("t1_en3", men_a, 1);
    chk("t1_we3", mwe_a, 0);
    chk("t1_rspv3", rspv_a, 0);
    tick();
    chk("t1_rspv4", rspv_a, 4'b0100);
    chk("t1_rspd4", rspd_a, 32'hA5A5_0001);
    chk("t1_en4", men_a, 0);
    chk("t1_we4", mwe_a, 0);
    tick();
    chk("t1_rspv5", rspv_a, 0);
    chk("t1_rspd5", rspd_a, 0);
    chk("t1_addr_hold", maddr_a, 8'h10);

    // All four continuously valid: bursts of four per requester
    do_reset();
    valid_a = 4'hF; we_a = 4'hF;
    for (int i = 0; i < 4; i++) addr_a[i] = 8'(i);
    for (int k = 0; k < 17; k++) begin
      #1;
      chk("t2_grant", ready_a, 64'(1) << ((k / 4) % 4));
      if (k > 0) begin
        chk("t2_en", men_a, 1);
        chk("t2_addr", maddr_a, 64'(((k - 1) / 4) % 4));
      end
      tick();
    end

    // Only requester 0: re-granted every cycle, count wraps after 4
    do_reset();
    valid_a = 4'b0001; we_a = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_grant", ready_a, 4'b0001);
      tick();
      chk("t4_cnt", dut_a.cnt, 64'((k % 4) + 1));
    end
    valid_a = '0;

    // QUANTUM=1: requesters 1 and 3 alternate, then 3 drops out
    do_reset();
    valid_b = 4'b1010;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) valid_b = 4'b0010;
      #1;
      chk("t3_grant", ready_b, 64'(1) << exp_seq3[k]);
      tick();
    end
    valid_b = '0;

    // MEM_LAT=3: reads from 0,1,2 on consecutive cycles
    do_reset();
    addr_b[0] = 8'h20; addr_b[1] = 8'h21; addr_b[2] = 8'h22;
    for (int k = 0; k < 3; k++) begin
      valid_b = 4'(1 << k);
      #1;
      chk("t5_grant", ready_b, 64'(1) << k);
      tick();
    end
    valid_b = '0;
    for (int m = 3; m < 8; m++) begin
      #1;
      if (m >= 4 && m <= 6) begin
        chk("t5_rspv", rspv_b, 64'(1) << (m - 4));
        chk("t5_rspd", rspd_b, 64'(32'h120 + m - 4));
      end else begin
        chk("t5_rspv_idle", rspv_b, 0);
        chk("t5_rspd_idle", rspd_b, 0);
      end
      tick();
    end

    // Reset one cycle after two reads issue: their responses are dropped
    do_reset();
    valid_b = 4'b0001; addr_b[0] = 8'h30;
    #1;
    chk("t6_grant0", ready_b, 4'b0001);
    tick();
    #1;
    chk("t6_grant1", ready_b, 4'b0001);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_ready_in_rst", ready_b, 0);
    tick();
    rst = 1'b0;
    valid_b = '0;
    #1;
    chk("t6_addr_after", maddr_b, 0);
    chk("t6_wdata_after", mwdata_b, 0);
    for (int m = 3; m < 8; m++) begin
      chk("t6_rspv", rspv_b, 0);
      chk("t6_rspd", rspd_b, 0);
      chk("t6_en", men_b, 0);
      tick();
    end
    valid_b = 4'hF;
    #1;
    chk("t6_first_grant", ready_b, 4'b0001);
    tick();
    valid_b = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
